// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a 5-stage in-order core. Detects load-use
// hazards between ID and EX, sequences the two flush slots that follow a
// jump/branch redirect, and freezes the pipe while memory is busy.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   id_rs1/id_rs2     : ID source register numbers
//   id_use_rs1/2      : ID instruction actually reads that source
//   ex_memread, ex_rd : EX instruction is a load, and its destination
//   jump              : jump resolved in EX this cycle
//   branch            : branch in EX
//   branch_check      : EX branch condition true
//   mem_busy          : instruction/data memory not ready, freeze pipe
//   load_use_hazard   : insert bubble into ID/EX
//   jump_delay        : second flush slot after a redirect
//   pc_stall          : hold PC
//   ifid_stall        : hold IF/ID
//   ifid_flush        : zero IF/ID
//   idex_flush        : zero ID/EX
//   stall_cycles      : saturating count of load-use bubble cycles
//   redirect_events   : saturating count of accepted redirects
//   dbg_state         : current FSM state (0 IDLE, 1 REDIR, 2 MEMWAIT)
//
// Handshake: there is no valid/ready handshake here; mem_busy acts as a
// global "not ready" that freezes every stage while it is high, and EX
// re-presents a frozen redirect once the freeze ends.
// ---------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        jump,
  input  logic        branch,
  input  logic        branch_check,
  input  logic        mem_busy,
  output logic        load_use_hazard,
  output logic        jump_delay,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [15:0] stall_cycles,
  output logic [15:0] redirect_events,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REDIR   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] redirect_events_q, redirect_events_d;

  logic redirect;
  logic rs1_match;
  logic rs2_match;
  logic lu_raw;
  logic redir_accept;

  assign redirect  = jump | (branch & branch_check);
  assign rs1_match = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 & (id_rs2 == ex_rd);
  // Loads to x0 never create a dependency.
  assign lu_raw    = ex_memread & (ex_rd != 5'd0) & (rs1_match | rs2_match);

  // A redirect is only taken from IDLE; in REDIR the EX slot is a bubble,
  // and during a freeze EX will present the redirect again afterwards.
  assign redir_accept = redirect & (state_q == ST_IDLE) & ~mem_busy;

  always_comb begin
    load_use_hazard = lu_raw & ~redirect & ~mem_busy & (state_q == ST_IDLE);
    jump_delay      = (state_q == ST_REDIR) & ~mem_busy;
    pc_stall        = load_use_hazard | mem_busy;
    ifid_stall      = load_use_hazard | mem_busy;
    ifid_flush      = redir_accept | jump_delay;
    idex_flush      = load_use_hazard | ifid_flush;
  end

  always_comb begin
    state_d           = state_q;
    ret_d             = ret_q;
    stall_cycles_d    = stall_cycles_q;
    redirect_events_d = redirect_events_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_busy) begin
          state_d = ST_MEMWAIT;
          ret_d   = ST_IDLE;
        end else if (redirect) begin
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (mem_busy) begin
          // Remember the owed flush slot so the freeze cannot swallow it.
          state_d = ST_MEMWAIT;
          ret_d   = ST_REDIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEMWAIT: begin
        if (!mem_busy) state_d = ret_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_use_hazard && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (redir_accept && redirect_events_q != 16'hFFFF)
      redirect_events_d = redirect_events_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      ret_q             <= ST_IDLE;
      stall_cycles_q    <= 16'd0;
      redirect_events_q <= 16'd0;
    end else begin
      state_q           <= state_d;
      ret_q             <= ret_d;
      stall_cycles_q    <= stall_cycles_d;
      redirect_events_q <= redirect_events_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign redirect_events = redirect_events_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors from
// IDLE, hand-written multi-cycle sequences (redirect slots, freeze during a
// redirect, counter saturation, reset), then random stimulus compared with
// a reference model that tracks "a flush slot is owed" and "the previous
// cycle was frozen" instead of an explicit state machine.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread;
  logic        jump, branch, branch_check, mem_busy;
  logic        load_use_hazard, jump_delay, pc_stall, ifid_stall;
  logic        ifid_flush, idex_flush;
  logic [15:0] stall_cycles, redirect_events;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .jump            (jump),
    .branch          (branch),
    .branch_check    (branch_check),
    .mem_busy        (mem_busy),
    .load_use_hazard (load_use_hazard),
    .jump_delay      (jump_delay),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .stall_cycles    (stall_cycles),
    .redirect_events (redirect_events),
    .dbg_state       (dbg_state)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memread, jmp, br, bchk, busy;
    logic [5:0] exp; // {lu, jd, pc_stall, ifid_stall, ifid_flush, idex_flush}
  } vec_t;

  vec_t vecs[$];

  // Driver tasks
  task automatic clr_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0;
    jump = 0; branch = 0; branch_check = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic apply_vec(vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
    id_use_rs1 = v.use1; id_use_rs2 = v.use2; ex_memread = v.memread;
    jump = v.jmp; branch = v.br; branch_check = v.bchk; mem_busy = v.busy;
  endtask

  // Scoreboard compare
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {load_use_hazard, jump_delay, pc_stall, ifid_stall, ifid_flush, idex_flush};
  endfunction

  task automatic add_vec(string nm, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic use1, logic use2, logic mr, logic jmp, logic br,
                         logic bchk, logic busy, logic [5:0] exp);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.use1 = use1; v.use2 = use2;
    v.memread = mr; v.jmp = jmp; v.br = br; v.bchk = bchk; v.busy = busy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Reference model state
  bit m_owe;       // a second flush slot is still owed
  bit m_prev_busy; // the previous cycle was frozen
  int m_stalls;
  int m_redirs;

  initial begin
    rst = 1'b0;
    clr_in();

    //        name          rs1 rs2 rd u1 u2 mr j  b  bc busy  lu jd ps is if xf
    add_vec("lu_rs2",       0,  5,  5, 0, 1, 1, 0, 0, 0, 0, 6'b101101);
    add_vec("lu_rs1",       7,  0,  7, 1, 0, 1, 0, 0, 0, 0, 6'b101101);
    add_vec("load_x0",      0,  0,  0, 1, 1, 1, 0, 0, 0, 0, 6'b000000);
    add_vec("br_over_lu",   5,  0,  5, 1, 0, 1, 0, 1, 1, 0, 6'b000011);
    add_vec("busy_wins",    5,  0,  5, 1, 0, 1, 1, 0, 0, 1, 6'b001100);
    add_vec("rs1_unused",   9,  0,  9, 0, 0, 1, 0, 0, 0, 0, 6'b000000);
    add_vec("not_load",     3,  3,  3, 1, 1, 0, 0, 0, 0, 0, 6'b000000);
    add_vec("br_not_taken", 0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 6'b000000);
    add_vec("jump_only",    0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 6'b000011);
    add_vec("no_match",     4,  6,  5, 1, 1, 1, 0, 0, 0, 0, 6'b000000);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_redirect_events", redirect_events, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_outs", outs(), 6'b000000);

    // Table vectors, each from a fresh IDLE
    foreach (vecs[i]) begin
      do_reset();
      apply_vec(vecs[i]);
      @(negedge clk);
      chk({"vec_", vecs[i].name}, outs(), vecs[i].exp);
    end

    // Load-use bumps stall_cycles by one
    do_reset();
    clr_in();
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    tick();
    chk("lu_stall_cnt", stall_cycles, 1);
    clr_in();

    // One-cycle jump pulse: two flush slots
    do_reset();
    jump = 1;
    @(negedge clk);
    chk("jmp_c0", outs(), 6'b000011);
    tick();
    jump = 0;
    @(negedge clk);
    chk("jmp_c1", outs(), 6'b010011);
    tick();
    @(negedge clk);
    chk("jmp_c2", outs(), 6'b000000);
    chk("jmp_redirects", redirect_events, 1);

    // Redirect, then a 3-cycle freeze starting in the REDIR slot
    do_reset();
    jump = 1;
    tick();
    jump = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_busy", outs(), 6'b001100);
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    chk("frz_release", outs(), 6'b000000);
    tick();
    @(negedge clk);
    chk("frz_slot", outs(), 6'b010011);
    tick();
    jump = 1;
    @(negedge clk);
    chk("frz_idle_accepts", outs(), 6'b000011);
    tick();
    jump = 0;
    chk("frz_redirects", redirect_events, 2);

    // Saturation of stall_cycles, then reset clears everything
    do_reset();
    clr_in();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    repeat (65535) tick();
    chk("sat_reach", stall_cycles, 16'hFFFF);
    @(negedge clk);
    chk("sat_still_lu", load_use_hazard, 1);
    tick();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    clr_in();
    rst = 1;
    tick();
    rst = 0;
    chk("sat_rst_stalls", stall_cycles, 0);
    chk("sat_rst_redirs", redirect_events, 0);
    chk("sat_rst_state", dbg_state, 0);

    // Mid-REDIR reset discards the owed slot
    jump = 1;
    tick();
    jump = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_drops_slot", outs(), 6'b000000);

    // Random stimulus against the reference model
    do_reset();
    m_owe = 0; m_prev_busy = 0; m_stalls = 0; m_redirs = 0;
    for (int n = 0; n < 4000; n++) begin
      logic redirect_m, raw_m, idle_m, redir_m, take_m, jd_m, lu_m;
      logic [5:0] exp_o;
      rst          = ($urandom_range(0, 99) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      jump         = ($urandom_range(0, 5) == 0);
      branch       = 1'($urandom_range(0, 1));
      branch_check = ($urandom_range(0, 3) == 0);
      mem_busy     = ($urandom_range(0, 4) == 0);

      redirect_m = jump || (branch && branch_check);
      raw_m  = ex_memread && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      idle_m  = !m_prev_busy && !m_owe;
      redir_m = !m_prev_busy && m_owe;
      take_m  = redirect_m && idle_m && !mem_busy;
      jd_m    = redir_m && !mem_busy;
      lu_m    = raw_m && !redirect_m && !mem_busy && idle_m;
      exp_o   = {lu_m, jd_m, lu_m || mem_busy, lu_m || mem_busy,
                 take_m || jd_m, lu_m || take_m || jd_m};

      @(negedge clk);
      chk("rnd_outs", outs(), exp_o);
      chk("rnd_stalls", stall_cycles, m_stalls);
      chk("rnd_redirs", redirect_events, m_redirs);

      if (rst) begin
        m_owe = 0; m_prev_busy = 0; m_stalls = 0; m_redirs = 0;
      end else begin
        if (take_m) begin
          m_owe = 1;
          if (m_redirs < 65535) m_redirs++;
        end
        if (jd_m) m_owe = 0;
        if (lu_m && m_stalls < 65535) m_stalls++;
        m_prev_busy = mem_busy;
      end
      tick();
    end
    rst = 0;

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
